mips_store_merge: RTL

Store-path lane formatter for the MIPS core, performing the inverse of load sign/zero extension. It takes an SB/SH/SW request (register value plus byte address) and writes it to a word-addressed memory port that has no byte enables. Byte and half stores use a read-modify-write: read the containing word, merge the low byte or half of the register into the addressed lane, write the word back. It sits between the execute/memory stage and the data-memory port.

---
 rtl/mips_store_merge_if.sv | 27 ++
 rtl/mips_store_merge.sv | 97 +++++++++
 2 files changed

// File: rtl/mips_store_merge_if.sv
// Store request and data-memory port bundle for the store lane formatter.
// slave is the formatter's view, master is the requester/memory side.
interface mips_store_merge_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        done;
    logic        err;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_readdata, mem_waitrequest,
        output req_ready, done, err, mem_address, mem_read, mem_write, mem_writedata
    );

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_readdata, mem_waitrequest,
        input  req_ready, done, err, mem_address, mem_read, mem_write, mem_writedata
    );
endinterface

// File: rtl/mips_store_merge.sv
// Store lane formatter: SW written directly, SB/SH via read-modify-write of the word.
// Latency (no waits): word done at +2, byte/half at +3, error at +1 after acceptance.
// Backpressure: one request in flight, req_ready only in IDLE; waitrequest holds strobes.
module mips_store_merge (
    input  logic               clk,
    input  logic               rst_n,
    mips_store_merge_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [15:0] data_q;
    logic [1:0]  size_q;
    logic        err_q;
    logic [31:0] merge_q;
    logic [31:0] merged;
    logic        req_err;
    logic        accept;

    assign accept = bus.req_valid && (state_q == IDLE);

    always_comb begin
        req_err = 1'b0;
        case (bus.req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = bus.req_addr[0];
            2'b10:   req_err = (bus.req_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
    end

    // Lane replacement applied to the word returned by the read phase.
    always_comb begin
        merged = bus.mem_readdata;
        if (size_q == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_err)
                        state_d = RESP;
                    else if (bus.req_size == 2'b10)
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ:    if (!bus.mem_waitrequest) state_d = WRITE;
            WRITE:   if (!bus.mem_waitrequest) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A word store preloads the whole register; byte/half overwrite it when the read lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= '0;
            err_q   <= 1'b0;
            merge_q <= '0;
        end else if (accept) begin
            addr_q  <= bus.req_addr;
            data_q  <= bus.req_data[15:0];
            size_q  <= bus.req_size;
            err_q   <= req_err;
            merge_q <= bus.req_data;
        end else if ((state_q == READ) && !bus.mem_waitrequest) begin
            merge_q <= merged;
        end
    end

    always_comb begin
        bus.req_ready     = (state_q == IDLE);
        bus.mem_read      = (state_q == READ);
        bus.mem_write     = (state_q == WRITE);
        bus.done          = (state_q == RESP);
        bus.err           = (state_q == RESP) && err_q;
        bus.mem_address   = {addr_q[31:2], 2'b00};
        bus.mem_writedata = merge_q;
    end
endmodule
